// File: rtl/spi_byte_port.sv
// ---------------------------------------------------------------------------
// spi_byte_port
//
// SPI mode-0 slave byte port sitting next to the FPU command core. The SPI
// pins are oversampled on the system clock, so SCLK may run at most at one
// sixth of the system clock (each SCLK phase must last at least three system
// clock periods).
//
// Receive side: MOSI is shifted in MSB first on rising SCLK edges. Each
// completed byte is presented on in_data with a one-cycle in_data_valid
// pulse.
//
// Transmit side: a reply byte is accepted through a valid/ready handshake
// into a one-entry holding register. At every byte boundary (frame start,
// or the falling SCLK edge that follows the 8th bit) the transmit shifter
// loads the held byte. If nothing is held, it loads IDLE_BYTE and flags
// tx_underrun for one cycle. MISO presents the transmit shifter MSB while
// the frame is active.
//
// Parameters:
//   SYNC_STAGES - synchronizer flops per SPI input pin (2 or more)
//   IDLE_BYTE   - byte shifted out when no reply byte is held
//
// Ports:
//   clock               - system clock
//   reset               - asynchronous reset, active low
//   SPI_clock           - SCLK from the master (asynchronous)
//   SPI_in              - MOSI
//   SPI_not_chip_select - CS_n, active low
//   SPI_out             - MISO (0 outside a frame)
//   in_data             - last received byte
//   in_data_valid       - one-cycle pulse, in_data holds a new byte
//   out_data            - reply byte
//   out_data_valid      - reply byte offered
//   out_data_ready      - holding register empty
//   frame_active        - synchronized chip select asserted
//   tx_underrun         - one-cycle pulse, IDLE_BYTE loaded for a byte slot
// ---------------------------------------------------------------------------
module spi_byte_port #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SPI_clock,
  input  logic       SPI_in,
  input  logic       SPI_not_chip_select,
  output logic       SPI_out,
  output logic [7:0] in_data,
  output logic       in_data_valid,
  input  logic [7:0] out_data,
  input  logic       out_data_valid,
  output logic       out_data_ready,
  output logic       frame_active,
  output logic       tx_underrun
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_t;

  frame_state_t state;
  frame_state_t state_next;

  // Synchronizer chains. Index 0 is closest to the pin.
  logic [SYNC_STAGES-1:0] sclk_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic [SYNC_STAGES-1:0] cs_pipe;

  // One extra copy of the synchronized SCLK and CS for edge detection.
  logic sclk_prev;
  logic cs_prev;

  logic sclk_sync;
  logic mosi_sync;
  logic cs_sync;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // Frame control strobes produced by the frame FSM.
  logic frame_open;
  logic frame_close;
  logic rx_step;
  logic tx_step;

  // Datapath state.
  logic [2:0] bit_count;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_reg;
  logic       hold_full;

  // Datapath control.
  logic       tx_load;
  logic       tx_advance;
  logic       hold_consume;
  logic       handshake;
  logic       hold_full_next;
  logic       byte_done;
  logic [7:0] rx_next;

  // All three pins go through identical chains, so MOSI reaches the
  // synchronized domain in the same cycle as the SCLK edge that samples it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      cs_pipe   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SPI_clock};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], SPI_in};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], SPI_not_chip_select};
      sclk_prev <= sclk_pipe[SYNC_STAGES-1];
      cs_prev   <= cs_pipe[SYNC_STAGES-1];
    end
  end

  assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
  assign cs_sync   = cs_pipe[SYNC_STAGES-1];

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign cs_fall   = ~cs_sync & cs_prev;
  assign cs_rise   = cs_sync & ~cs_prev;

  // Frame FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame FSM next state and strobes. SCLK edges are only honoured inside
  // a frame. A CS release in the same cycle as an SCLK edge closes the frame,
  // and that edge is dropped.
  always_comb begin
    state_next  = state;
    frame_open  = 1'b0;
    frame_close = 1'b0;
    rx_step     = 1'b0;
    tx_step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_FRAME;
          frame_open = 1'b1;
        end
      end
      ST_FRAME: begin
        if (cs_rise) begin
          state_next  = ST_IDLE;
          frame_close = 1'b1;
        end else begin
          rx_step = sclk_rise;
          tx_step = sclk_fall;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign frame_active = (state == ST_FRAME);

  // A byte slot begins at frame start, or at the falling edge after a
  // completed byte (bit_count has already wrapped back to 0 by then).
  assign tx_load      = frame_open | (tx_step & (bit_count == 3'd0));
  assign tx_advance   = tx_step & (bit_count != 3'd0);
  assign hold_consume = tx_load & hold_full;
  assign handshake    = out_data_valid & out_data_ready;
  assign byte_done    = rx_step & (bit_count == 3'd7);
  assign rx_next      = {rx_shift[6:0], mosi_sync};

  // Ready is low whenever the register is full, so a handshake and a
  // consume can never fall in the same cycle.
  always_comb begin
    hold_full_next = hold_full;
    if (handshake) begin
      hold_full_next = 1'b1;
    end else if (hold_consume) begin
      hold_full_next = 1'b0;
    end
  end

  // Bit counter. It restarts at every frame boundary, which discards any
  // partially received byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_count <= 3'd0;
    end else if (frame_open || frame_close) begin
      bit_count <= 3'd0;
    end else if (rx_step) begin
      bit_count <= bit_count + 3'd1;
    end
  end

  // Receive shifter and byte delivery.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_shift      <= 8'h00;
      in_data       <= 8'h00;
      in_data_valid <= 1'b0;
    end else begin
      in_data_valid <= byte_done;
      if (rx_step) begin
        rx_shift <= rx_next;
      end
      if (byte_done) begin
        in_data <= rx_next;
      end
    end
  end

  // Reply holding register and handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_reg       <= 8'h00;
      hold_full      <= 1'b0;
      out_data_ready <= 1'b1;
    end else begin
      hold_full      <= hold_full_next;
      out_data_ready <= ~hold_full_next;
      if (handshake) begin
        hold_reg <= out_data;
      end
    end
  end

  // Transmit shifter. Shifts happen on falling SCLK edges so MISO is stable
  // before the master samples it on the next rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_shift    <= IDLE_BYTE;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= tx_load & ~hold_full;
      if (tx_load) begin
        tx_shift <= hold_full ? hold_reg : IDLE_BYTE;
      end else if (tx_advance) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign SPI_out = frame_active & tx_shift[7];

endmodule

// File: tb/tb_spi_byte_port.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_port
//
// Directed bench for spi_byte_port. It acts as an SPI master and as the
// reply-byte producer. Received bytes are pushed to a scoreboard queue as
// they are driven and are popped when the port pulses in_data_valid. Reply
// bytes are queued in a small holding model that predicts each MISO byte
// and every tx_underrun pulse.
// ---------------------------------------------------------------------------
module tb_spi_byte_port;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;
  // SCLK half period in system clocks.
  localparam int         HALF        = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       SPI_clock = 1'b0;
  logic       SPI_in = 1'b0;
  logic       SPI_not_chip_select = 1'b1;
  logic       SPI_out;
  logic [7:0] in_data;
  logic       in_data_valid;
  logic [7:0] out_data = 8'h00;
  logic       out_data_valid = 1'b0;
  logic       out_data_ready;
  logic       frame_active;
  logic       tx_underrun;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int validCount = 0;
  int underrunCount = 0;
  int expValid = 0;
  int expUnderrun = 0;
  int lastRiseCycle = 0;

  logic [7:0] rxQueue[$];
  logic [7:0] holdQueue[$];
  logic [7:0] txCurrent = 8'h00;

  spi_byte_port #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_BYTE  (IDLE_BYTE)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .SPI_clock          (SPI_clock),
    .SPI_in             (SPI_in),
    .SPI_not_chip_select(SPI_not_chip_select),
    .SPI_out            (SPI_out),
    .in_data            (in_data),
    .in_data_valid      (in_data_valid),
    .out_data           (out_data),
    .out_data_valid     (out_data_valid),
    .out_data_ready     (out_data_ready),
    .frame_active       (frame_active),
    .tx_underrun        (tx_underrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Receive scoreboard and pulse counters, sampled away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (in_data_valid === 1'b1) begin
        validCount++;
        if (rxQueue.size() > 0) begin
          checkOutput("rx_byte", {24'h0, in_data}, {24'h0, rxQueue.pop_front()});
          checkOutput("rx_latency_ok",
                      {31'h0, ((cycleCount - lastRiseCycle) <= SYNC_STAGES + 2)}, 1);
        end
      end
      if (tx_underrun === 1'b1) underrunCount++;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Model of a byte-slot load: the held byte if any, else IDLE_BYTE.
  task automatic loadModel();
    if (holdQueue.size() > 0) begin
      txCurrent = holdQueue.pop_front();
    end else begin
      txCurrent = IDLE_BYTE;
      expUnderrun++;
    end
  endtask

  task automatic offerByte(input logic [7:0] value);
    bit accepted;
    accepted = 1'b0;
    out_data = value;
    out_data_valid = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(posedge clock);
      if (out_data_ready === 1'b1) accepted = 1'b1;
    end
    #1;
    out_data_valid = 1'b0;
    checkOutput("offer_accepted", {31'h0, accepted}, 1);
    if (accepted) holdQueue.push_back(value);
  endtask

  task automatic frameStart();
    SPI_not_chip_select = 1'b0;
    waitCycles(HALF);
    loadModel();
  endtask

  task automatic frameEnd();
    waitCycles(HALF);
    SPI_not_chip_select = 1'b1;
    waitCycles(2 * HALF);
  endtask

  // Clocks nbits of mosiByte out MSB first and samples MISO before each
  // rising edge. Optionally offers a reply byte once the 8th bit is seen.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nbits,
                               input bit doOffer, input logic [7:0] offerVal);
    logic [7:0] misoByte;
    logic [7:0] expMiso;
    bit seen;
    misoByte = 8'h00;
    expMiso = txCurrent;
    for (int i = 0; i < nbits; i++) begin
      SPI_in = mosiByte[7-i];
      waitCycles(HALF);
      misoByte = {misoByte[6:0], SPI_out};
      SPI_clock = 1'b1;
      if (i == 7) begin
        lastRiseCycle = cycleCount;
        rxQueue.push_back(mosiByte);
        expValid++;
        if (doOffer) begin
          seen = 1'b0;
          for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (in_data_valid === 1'b1) seen = 1'b1;
          end
          checkOutput("valid_before_offer", {31'h0, seen}, 1);
          offerByte(offerVal);
        end
      end
      waitCycles(HALF);
      SPI_clock = 1'b0;
    end
    if (nbits == 8) begin
      checkOutput("miso_byte", {24'h0, misoByte}, {24'h0, expMiso});
      loadModel();
    end
  endtask

  initial begin
    // Reset held with pins toggling.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SPI_clock = i[0];
      SPI_not_chip_select = i[1];
      SPI_in = ~i[0];
      waitCycles(2);
    end
    checkOutput("rst_in_data", {24'h0, in_data}, 0);
    checkOutput("rst_in_valid", {31'h0, in_data_valid}, 0);
    checkOutput("rst_ready", {31'h0, out_data_ready}, 1);
    checkOutput("rst_frame", {31'h0, frame_active}, 0);
    checkOutput("rst_underrun", {31'h0, tx_underrun}, 0);
    checkOutput("rst_miso", {31'h0, SPI_out}, 0);
    SPI_clock = 1'b0;
    SPI_not_chip_select = 1'b1;
    SPI_in = 1'b0;
    waitCycles(2);
    reset = 1'b1;
    waitCycles(20);
    checkOutput("post_rst_valid_count", validCount, 0);
    checkOutput("post_rst_underrun_count", underrunCount, 0);
    checkOutput("post_rst_frame", {31'h0, frame_active}, 0);

    // Single receive with nothing offered: MISO carries IDLE_BYTE.
    $display("[TB] single receive / underrun");
    frameStart();
    checkOutput("frame_active_on", {31'h0, frame_active}, 1);
    applyStimulus(8'hA5, 8, 1'b0, 8'h00);
    frameEnd();
    checkOutput("single_valid_count", validCount, expValid);
    checkOutput("single_underrun_count", underrunCount, expUnderrun);
    checkOutput("frame_active_off", {31'h0, frame_active}, 0);

    // Preloaded reply byte.
    $display("[TB] preloaded reply");
    offerByte(8'h3C);
    checkOutput("preload_ready_low", {31'h0, out_data_ready}, 0);
    frameStart();
    checkOutput("preload_ready_back", {31'h0, out_data_ready}, 1);
    checkOutput("preload_no_underrun", underrunCount, expUnderrun);
    applyStimulus(8'hC3, 8, 1'b0, 8'h00);
    frameEnd();
    checkOutput("preload_valid_count", validCount, expValid);
    checkOutput("preload_underrun_count", underrunCount, expUnderrun);

    // Back-to-back full duplex.
    $display("[TB] back-to-back");
    offerByte(8'h10);
    frameStart();
    applyStimulus(8'h01, 8, 1'b1, 8'h20);
    applyStimulus(8'h02, 8, 1'b1, 8'h30);
    applyStimulus(8'h03, 8, 1'b0, 8'h00);
    frameEnd();
    checkOutput("b2b_valid_count", validCount, expValid);
    checkOutput("b2b_underrun_count", underrunCount, expUnderrun);

    // Aborted frame after 5 bits, then a clean frame.
    $display("[TB] abort");
    frameStart();
    applyStimulus(8'hB7, 5, 1'b0, 8'h00);
    frameEnd();
    checkOutput("abort_valid_count", validCount, expValid);
    frameStart();
    applyStimulus(8'h7E, 8, 1'b0, 8'h00);
    frameEnd();
    checkOutput("after_abort_valid_count", validCount, expValid);
    checkOutput("after_abort_underrun_count", underrunCount, expUnderrun);
    checkOutput("after_abort_in_data", {24'h0, in_data}, 32'h7E);

    // Asynchronous reset in the middle of a byte with a reply held.
    $display("[TB] async reset");
    frameStart();
    offerByte(8'h55);
    checkOutput("mid_ready_low", {31'h0, out_data_ready}, 0);
    applyStimulus(8'hE0, 3, 1'b0, 8'h00);
    SPI_in = 1'b0;
    waitCycles(HALF);
    SPI_clock = 1'b1;
    waitCycles(3);
    checkOutput("mid_frame_active", {31'h0, frame_active}, 1);
    checkOutput("mid_miso", {31'h0, SPI_out}, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_frame", {31'h0, frame_active}, 0);
    checkOutput("async_miso", {31'h0, SPI_out}, 0);
    checkOutput("async_ready", {31'h0, out_data_ready}, 1);
    checkOutput("async_in_data", {24'h0, in_data}, 0);
    checkOutput("async_underrun", {31'h0, tx_underrun}, 0);
    holdQueue.delete();
    SPI_clock = 1'b0;
    SPI_not_chip_select = 1'b1;
    waitCycles(4);
    reset = 1'b1;
    waitCycles(20);
    checkOutput("final_valid_count", validCount, expValid);
    checkOutput("final_underrun_count", underrunCount, expUnderrun);
    checkOutput("final_rx_queue_empty", rxQueue.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
